// File: rtl/set_assoc_read_cache.sv
// set_assoc_read_cache
//   N-way set-associative, read-only, blocking cache between the CPU load
//   port and main memory. Each way of each set holds one tag, one valid bit
//   and LINE_WORDS data words. A miss fills the whole line from memory as a
//   burst. The victim is the lowest-index invalid way. If every way is
//   valid, the set's round-robin pointer picks the victim. A bulk
//   invalidate clears the valid bits one set per cycle.
//
//   Optional feature: define CACHE_STATS_EN to add the saturating 32-bit
//   hit_count / miss_count output ports.
//
// Ports
//   clock          clock
//   reset          asynchronous, active-low reset
//   req_valid      CPU read request
//   req_ready      high only while idle
//   req_addr       byte address; low OFF_W bits ignored
//   resp_valid     one-cycle pulse qualifying resp_hit / resp_data
//   resp_hit       1 = served from cache, 0 = served after a fill
//   resp_data      requested word; holds its value between pulses
//   mem_req_valid  line fill request
//   mem_req_ready  memory accepts the fill request
//   mem_req_addr   line-aligned fill address
//   mem_rsp_valid  one fill beat valid (word 0 first)
//   mem_rsp_data   fill beat data
//   invalidate     invalidate-all request, sampled only while idle
//   hit_count      (CACHE_STATS_EN) responses served from cache
//   miss_count     (CACHE_STATS_EN) responses served after a fill
module set_assoc_read_cache #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 64,
  parameter int WAYS       = 8,
  parameter int SETS       = 512,
  parameter int LINE_WORDS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WORD_W-1:0] resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [WORD_W-1:0] mem_rsp_data,
  input  logic              invalidate
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W = $clog2(WORD_W / 8);
  localparam int WI_W  = $clog2(LINE_WORDS);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - OFF_W - WI_W - SET_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    FILL,
    RESPOND,
    FLUSH
  } state_t;

  state_t state_q, state_d;

  // Latched request address. The byte offset is never needed, so it is not stored.
  logic [ADDR_W-1:OFF_W]    addr_q;
  logic [TAG_W-1:0]         req_tag;
  logic [SET_W-1:0]         req_set;
  logic [WI_W-1:0]          req_wi;

  // Valid bits and round-robin pointers are flat vectors so that reset can
  // clear them in one assignment. They are indexed as {set, way} and by set.
  logic [SETS*WAYS-1:0]     valid_q;
  logic [SETS*WAY_W-1:0]    rr_ptr_q;
  logic [TAG_W-1:0]         tag_mem  [SETS*WAYS];
  logic [WORD_W-1:0]        data_mem [SETS*WAYS*LINE_WORDS];

  logic [WAY_W-1:0]         victim_q;
  logic                     by_ptr_q;
  logic [WI_W-1:0]          beat_q;
  logic [WORD_W-1:0]        fill_word_q;
  logic [SET_W-1:0]         flush_q;

  logic                     resp_valid_q;
  logic                     resp_hit_q;
  logic [WORD_W-1:0]        resp_data_q;

  logic [WAYS-1:0]          set_valid;
  logic                     hit;
  logic [WAY_W-1:0]         hit_way;
  logic                     free_found;
  logic [WAY_W-1:0]         free_way;
  logic [WORD_W-1:0]        hit_word;
  logic [WAY_W-1:0]         set_ptr;
  logic                     last_beat;
  logic                     unused_addr_bits;

  assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign req_set   = addr_q[OFF_W+WI_W +: SET_W];
  assign req_wi    = addr_q[OFF_W +: WI_W];
  assign set_valid = valid_q[req_set*WAYS +: WAYS];
  assign set_ptr   = rr_ptr_q[req_set*WAY_W +: WAY_W];
  assign last_beat = (beat_q == WI_W'(LINE_WORDS - 1));

  assign mem_req_addr     = {addr_q[ADDR_W-1:OFF_W+WI_W], {(OFF_W+WI_W){1'b0}}};
  assign resp_valid       = resp_valid_q;
  assign resp_hit         = resp_hit_q;
  assign resp_data        = resp_data_q;
  assign unused_addr_bits = ^req_addr[OFF_W-1:0];

  // Compare the tag against every way of the set. Invalid ways never match.
  // The same loop finds the lowest-index invalid way, which becomes the
  // preferred victim on a miss.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (set_valid[w] && (tag_mem[{req_set, WAY_W'(w)}] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!set_valid[w] && !free_found) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
    hit_word = data_mem[{req_set, hit_way, req_wi}];
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the handshake outputs. A request that arrives in
  // the same cycle as invalidate is served first.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = LOOKUP;
        end else if (invalidate) begin
          state_d = FLUSH;
        end
      end
      LOOKUP:   state_d = hit ? IDLE : MISS_REQ;
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (mem_rsp_valid && last_beat) begin
          state_d = RESPOND;
        end
      end
      RESPOND:  state_d = IDLE;
      FLUSH: begin
        if (flush_q == SET_W'(SETS - 1)) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // Control datapath: address latch, victim selection, beat counting,
  // valid/pointer maintenance, flush walk and the registered response.
  // On a miss the response word comes from fill_word_q. If the requested
  // word is the last beat, it comes straight from the bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      valid_q      <= '0;
      rr_ptr_q     <= '0;
      victim_q     <= '0;
      by_ptr_q     <= 1'b0;
      beat_q       <= '0;
      fill_word_q  <= '0;
      flush_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr[ADDR_W-1:OFF_W];
          end else if (invalidate) begin
            flush_q <= '0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_data_q  <= hit_word;
          end else begin
            victim_q <= free_found ? free_way : set_ptr;
            by_ptr_q <= !free_found;
            beat_q   <= '0;
          end
        end
        FILL: begin
          if (mem_rsp_valid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == req_wi) begin
              fill_word_q <= mem_rsp_data;
            end
            if (last_beat) begin
              valid_q[{req_set, victim_q}] <= 1'b1;
              if (by_ptr_q) begin
                rr_ptr_q[req_set*WAY_W +: WAY_W] <= victim_q + 1'b1;
              end
              resp_valid_q <= 1'b1;
              resp_hit_q   <= 1'b0;
              resp_data_q  <= (beat_q == req_wi) ? mem_rsp_data : fill_word_q;
            end
          end
        end
        FLUSH: begin
          valid_q[flush_q*WAYS +: WAYS] <= '0;
          flush_q                       <= flush_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage has no reset. A line is only trusted once its valid
  // bit is set, and that happens after the last beat of its fill.
  always_ff @(posedge clock) begin
    if ((state_q == FILL) && mem_rsp_valid) begin
      data_mem[{req_set, victim_q, beat_q}] <= mem_rsp_data;
      if (last_beat) begin
        tag_mem[{req_set, victim_q}] <= req_tag;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating response counters. They are cleared only by reset, not by invalidate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_valid_q) begin
      if (resp_hit_q) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
